// File: rtl/bcd16_to_bin_if.sv
// Request/result bundle for the five-digit BCD to 16-bit binary converter.
// The master drives the digits and start; the slave (converter) returns the result and flags.
interface bcd16_to_bin_if;
  logic        start;
  logic [3:0]  tk;
  logic [3:0]  k;
  logic [3:0]  h;
  logic [3:0]  t;
  logic [3:0]  s;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        err;
  logic        ovf;

  modport master (
    output start, tk, k, h, t, s,
    input  bin, busy, done, err, ovf
  );

  modport slave (
    input  start, tk, k, h, t, s,
    output bin, busy, done, err, ovf
  );
endinterface

// File: rtl/bcd16_to_bin.sv
// Sequential five-digit BCD to 16-bit binary converter (reverse double dabble).
// Each CONV cycle shifts {bcd,bin} right once and corrects the BCD nibbles; 16 cycles per result.
module bcd16_to_bin (
  input  logic            clk,
  input  logic            nreset,
  bcd16_to_bin_if.slave   bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t      state_r;
  logic [19:0] bcd_r;
  logic [15:0] bin_r;
  logic [3:0]  cnt_r;
  logic [15:0] bin_out_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        ovf_r;

  logic        digit_err_s;
  logic [19:0] bcd_sh_s;
  logic [15:0] bin_sh_s;
  logic [19:0] bcd_fix_s;

  function automatic logic [3:0] nib_fix(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd8) r = n - 4'd3;
    else           r = n;
    return r;
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  // Digit validation and one shift/correct step of the datapath.
  always_comb begin
    digit_err_s = digit_bad(bus.tk) | digit_bad(bus.k) | digit_bad(bus.h) |
                  digit_bad(bus.t)  | digit_bad(bus.s);
    bcd_sh_s    = {1'b0, bcd_r[19:1]};
    bin_sh_s    = {bcd_r[0], bin_r[15:1]};
    bcd_fix_s   = 20'd0;
    for (int i = 0; i < 5; i++) begin
      bcd_fix_s[4*i +: 4] = nib_fix(bcd_sh_s[4*i +: 4]);
    end
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r   <= IDLE;
      bcd_r     <= 20'd0;
      bin_r     <= 16'd0;
      cnt_r     <= 4'd0;
      bin_out_r <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if (digit_err_s) begin
              bin_out_r <= 16'd0;
              err_r     <= 1'b1;
              ovf_r     <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              bcd_r   <= {bus.tk, bus.k, bus.h, bus.t, bus.s};
              bin_r   <= 16'd0;
              cnt_r   <= 4'd0;
              err_r   <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= CONV;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          bcd_r <= bcd_fix_s;
          bin_r <= bin_sh_s;
          cnt_r <= cnt_r + 4'd1;
          // Whatever remains in the BCD field is the value above 16 bits.
          if (cnt_r == 4'd15) begin
            bin_out_r <= bin_sh_s;
            ovf_r     <= (bcd_fix_s != 20'd0);
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= CONV;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bin  = bin_out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.ovf  = ovf_r;

endmodule
